// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the serial ShiftRows/MixColumns stage.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  col_t;
  typedef logic [127:0] aes_state_t;

  localparam byte_t AES_POLY = 8'h1b;

  function automatic byte_t xtime(input byte_t a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
  endfunction

  // Byte k sits at [127-8k -: 8]; row = k%4, column = k/4.
  function automatic aes_state_t shift_rows(input aes_state_t s);
    aes_state_t r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rr = 0; rr < 4; rr++) begin
        r[127-8*(4*c+rr) -: 8] = s[127-8*(4*((c+rr)%4)+rr) -: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mix_columns_serial_if.sv
// Upstream/downstream handshake bundle for mix_columns_serial.
interface mix_columns_serial_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  modport master (
    output in_valid, in_state, in_last, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, in_last, out_ready,
    output in_ready, out_valid, out_state
  );
endinterface

// File: rtl/mix_columns_serial_mix_single_column.sv
// Combinational MixColumns on one 32-bit column (a0 in the top byte).
module mix_single_column
  import aes_pkg::*;
(
  input  col_t a,
  output col_t b
);
  byte_t a0, a1, a2, a3;

  assign a0 = a[31:24];
  assign a1 = a[23:16];
  assign a2 = a[15:8];
  assign a3 = a[7:0];

  // 3*x is xtime(x) ^ x
  assign b[31:24] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
  assign b[23:16] = xtime(a1) ^ xtime(a2) ^ a2 ^ a3 ^ a0;
  assign b[15:8]  = xtime(a2) ^ xtime(a3) ^ a3 ^ a0 ^ a1;
  assign b[7:0]   = xtime(a3) ^ xtime(a0) ^ a0 ^ a1 ^ a2;
endmodule

// File: rtl/mix_columns_serial.sv
// Serial ShiftRows + MixColumns, one column per cycle through a shared multiplier.
// Define MIXCOL_LAST_ROUND_EN to honour in_last (ShiftRows-only final round).
module mix_columns_serial
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  mix_columns_serial_if.slave  bus
);
  state_e     state_q, state_d;
  logic [1:0] col_q, col_d;
  logic       last_q, last_d;
  aes_state_t work_q, work_d;
  aes_state_t out_q, out_d;
  col_t       col_in, col_mixed, col_out;

  always_comb begin
    col_in = '0;
    case (col_q)
      2'd0: col_in = work_q[127:96];
      2'd1: col_in = work_q[95:64];
      2'd2: col_in = work_q[63:32];
      2'd3: col_in = work_q[31:0];
      default: col_in = '0;
    endcase
  end

  mix_single_column u_mix (
    .a (col_in),
    .b (col_mixed)
  );

`ifdef MIXCOL_LAST_ROUND_EN
  assign col_out = last_q ? col_in : col_mixed;
`else
  assign col_out = col_mixed;
  logic unused_last;
  assign unused_last = bus.in_last ^ last_q;
`endif

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    last_d  = last_q;
    work_d  = work_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          work_d  = shift_rows(bus.in_state);
`ifdef MIXCOL_LAST_ROUND_EN
          last_d  = bus.in_last;
`else
          last_d  = 1'b0;
`endif
          col_d   = 2'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        case (col_q)
          2'd0: out_d[127:96] = col_out;
          2'd1: out_d[95:64]  = col_out;
          2'd2: out_d[63:32]  = col_out;
          2'd3: out_d[31:0]   = col_out;
          default: out_d = out_q;
        endcase
        // col stops at 3 instead of wrapping; DONE takes over
        if (col_q == 2'd3) begin
          state_d = DONE;
        end else begin
          col_d = col_q + 2'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      last_q  <= 1'b0;
      work_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      last_q  <= last_d;
      work_q  <= work_d;
      out_q   <= out_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_state = out_q;

endmodule
